// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared constants and slot offset helper for demux10_dist
package demux_pkg;

  localparam int WIDTH = 16;
  localparam int NCH   = 10;
  localparam int SW    = 4;

  // Bit offset of slot k inside the packed y bus.
  function automatic int slot_off(input int k, input int w = WIDTH);
    return w * k;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// rtl/demux_slot.sv - one output slot: data register plus full flag
module demux_slot
  import demux_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         ack,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         valid,
  output logic         can_load
);

  logic [W-1:0] q_d, q_q;
  logic         valid_d, valid_q;

  // Next state: a load wins over a same-cycle ack; an ack only clears a full slot
  // and leaves the stale data in place.
  always_comb begin
    q_d     = q_q;
    valid_d = valid_q;
    if (load) begin
      q_d     = d;
      valid_d = 1'b1;
    end else if (ack && valid_q) begin
      valid_d = 1'b0;
    end
  end

  // Slot register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      q_q     <= q_d;
      valid_q <= valid_d;
    end
  end

  assign q        = q_q;
  assign valid    = valid_q;
  assign can_load = !valid_q || ack;

endmodule

// File: rtl/demux10_dist.sv
// rtl/demux10_dist.sv - steers one valid/ready word stream into ten held output slots
module demux10_dist
  import demux_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   d,
  input  logic [SW-1:0]      s,
  input  logic               auto,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [NCH*WIDTH-1:0] y,
  output logic [NCH-1:0]     out_valid,
  input  logic [NCH-1:0]     out_ack,
  output logic [SW-1:0]      ptr,
  output logic               sel_err
);

  logic [SW-1:0]  ptr_d, ptr_q;
  logic           sel_err_d, sel_err_q;
  logic [SW-1:0]  t;
  logic           in_range;
  logic           xfer;
  logic [NCH-1:0] load;
  logic [NCH-1:0] can_load;

  // Target decode, ready selection, slot load strobes and pointer/sel_err next state.
  always_comb begin
    t        = auto ? ptr_q : s;
    in_range = ({1'b0, t} < (SW+1)'(NCH));
    // A target with no slot behind it still accepts, so upstream never stalls on it.
    in_ready = 1'b1;
    for (int k = 0; k < NCH; k++) begin
      if (t == SW'(k)) in_ready = can_load[k];
    end
    xfer = in_valid && in_ready;
    load = '0;
    for (int k = 0; k < NCH; k++) begin
      load[k] = xfer && (t == SW'(k));
    end
    sel_err_d = xfer && !in_range;
    ptr_d     = ptr_q;
    if (auto && xfer) begin
      ptr_d = (ptr_q == SW'(NCH-1)) ? '0 : ptr_q + SW'(1);
    end
  end

  // Round-robin pointer and dropped-word flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q     <= '0;
      sel_err_q <= 1'b0;
    end else begin
      ptr_q     <= ptr_d;
      sel_err_q <= sel_err_d;
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_slot
    demux_slot #(.W(WIDTH)) u_slot (
      .clk      (clk),
      .rst      (rst),
      .load     (load[k]),
      .ack      (out_ack[k]),
      .d        (d),
      .q        (y[slot_off(k) +: WIDTH]),
      .valid    (out_valid[k]),
      .can_load (can_load[k])
    );
  end

  assign ptr     = ptr_q;
  assign sel_err = sel_err_q;

endmodule

// File: tb/tb_demux10_dist.sv
// tb/tb_demux10_dist.sv - randomized and directed self-checking bench for demux10_dist
module tb_demux10_dist;

  localparam int WIDTH = 16;
  localparam int NCH   = 10;
  localparam int SW    = 4;
  localparam int BW    = NCH * WIDTH;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [WIDTH-1:0]     d = '0;
  logic [SW-1:0]        s = '0;
  logic                 auto_sel = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [BW-1:0]        y;
  logic [NCH-1:0]       out_valid;
  logic [NCH-1:0]       out_ack = '0;
  logic [SW-1:0]        ptr;
  logic                 sel_err;

  demux10_dist dut (
    .clk       (clk),
    .rst       (rst),
    .d         (d),
    .s         (s),
    .auto      (auto_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y         (y),
    .out_valid (out_valid),
    .out_ack   (out_ack),
    .ptr       (ptr),
    .sel_err   (sel_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Behavioural model: ten mailboxes, a pointer and a drop flag.
  logic [WIDTH-1:0] m_data [NCH];
  bit               m_full [NCH];
  int               m_ptr;
  bit               m_err;

  function automatic int tgt();
    return auto_sel ? m_ptr : int'(s);
  endfunction

  function automatic bit m_ready();
    int t;
    t = tgt();
    if (t >= NCH) return 1'b1;
    return !m_full[t] || out_ack[t];
  endfunction

  task automatic check(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model update on each rising edge from the inputs held during the cycle.
  always @(posedge clk) begin
    int t;
    bit acc;
    if (rst) begin
      for (int k = 0; k < NCH; k++) begin
        m_data[k] = '0;
        m_full[k] = 1'b0;
      end
      m_ptr = 0;
      m_err = 1'b0;
    end else begin
      t   = tgt();
      acc = in_valid && m_ready();
      for (int k = 0; k < NCH; k++) begin
        if (out_ack[k]) m_full[k] = 1'b0;
      end
      m_err = 1'b0;
      if (acc) begin
        if (t < NCH) begin
          m_data[t] = d;
          m_full[t] = 1'b1;
        end else begin
          m_err = 1'b1;
        end
        if (auto_sel) m_ptr = (m_ptr + 1) % NCH;
      end
    end
  end

  // Every cycle: compare all DUT outputs with the model on the falling edge.
  always @(negedge clk) begin
    logic [BW-1:0]  ey;
    logic [NCH-1:0] ev;
    if (chk_en) begin
      for (int k = 0; k < NCH; k++) begin
        ey[k*WIDTH +: WIDTH] = m_data[k];
        ev[k] = m_full[k];
      end
      check("y", y, ey);
      check("out_valid", BW'(out_valid), BW'(ev));
      check("ptr", BW'(ptr), BW'(m_ptr));
      check("sel_err", BW'(sel_err), BW'(m_err));
      check("in_ready", BW'(in_ready), BW'(m_ready()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [WIDTH-1:0] w1 [NCH];
    w1 = '{16'h000A, 16'h000B, 16'h000C, 16'h000D, 16'h000E,
           16'h000F, 16'h0001, 16'h0002, 16'h0003, 16'h0004};

    rst = 1'b1;
    tick();
    chk_en = 1'b1;
    rst = 1'b0;
    check("rst_out_valid", BW'(out_valid), BW'(0));
    check("rst_y", y, '0);
    check("rst_ptr", BW'(ptr), BW'(0));
    check("rst_sel_err", BW'(sel_err), BW'(0));

    // Manual fill of all ten slots.
    auto_sel = 1'b0;
    out_ack  = '0;
    for (int k = 0; k < NCH; k++) begin
      s = SW'(k);
      d = w1[k];
      in_valid = 1'b1;
      @(negedge clk);
      check("fill_in_ready", BW'(in_ready), BW'(1));
      tick();
      check("fill_slot", BW'(y[k*WIDTH +: WIDTH]), BW'(w1[k]));
    end
    in_valid = 1'b0;
    check("fill_out_valid", BW'(out_valid), BW'(10'h3FF));

    // Backpressure on slot 3, then release by ack with same-cycle reload.
    s = 4'd3;
    d = 16'h1234;
    in_valid = 1'b1;
    @(negedge clk);
    check("bp_in_ready_low", BW'(in_ready), BW'(0));
    tick();
    check("bp_y3_held", BW'(y[3*WIDTH +: WIDTH]), BW'(16'h000D));
    out_ack = 10'h008;
    @(negedge clk);
    check("bp_in_ready_ack", BW'(in_ready), BW'(1));
    tick();
    in_valid = 1'b0;
    out_ack  = '0;
    check("bp_y3_new", BW'(y[3*WIDTH +: WIDTH]), BW'(16'h1234));
    check("bp_valid3", BW'(out_valid[3]), BW'(1));

    // Select beyond the last channel.
    s = 4'hC;
    d = 16'hBEEF;
    in_valid = 1'b1;
    @(negedge clk);
    check("bad_sel_in_ready", BW'(in_ready), BW'(1));
    tick();
    in_valid = 1'b0;
    check("bad_sel_err", BW'(sel_err), BW'(1));
    check("bad_sel_valid", BW'(out_valid), BW'(10'h3FF));
    tick();
    check("bad_sel_err_clear", BW'(sel_err), BW'(0));

    // Auto round-robin with every consumer acknowledging.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    auto_sel = 1'b1;
    out_ack  = '1;
    for (int i = 0; i < 12; i++) begin
      d = WIDTH'(i + 1);
      in_valid = 1'b1;
      @(negedge clk);
      check("rr_ptr", BW'(ptr), BW'(i % 10));
      tick();
    end
    in_valid = 1'b0;
    out_ack  = '0;
    check("rr_slot0", BW'(y[0 +: WIDTH]), BW'(16'h000B));
    check("rr_slot1", BW'(y[WIDTH +: WIDTH]), BW'(16'h000C));
    check("rr_ptr_end", BW'(ptr), BW'(2));

    // Reset in the middle of activity.
    out_ack = '1;
    for (int i = 0; i < 5; i++) begin
      d = WIDTH'(16'h0100 + i);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    tick();
    out_ack  = '0;
    auto_sel = 1'b0;
    in_valid = 1'b1;
    s = 4'd2; d = 16'h2222; tick();
    s = 4'd5; d = 16'h5555; tick();
    check("mid_ptr", BW'(ptr), BW'(7));
    check("mid_valid", BW'(out_valid), BW'(10'h024));
    rst = 1'b1;
    s = 4'd3;
    d = 16'h7777;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    check("mid_rst_valid", BW'(out_valid), BW'(0));
    check("mid_rst_y", y, '0);
    check("mid_rst_ptr", BW'(ptr), BW'(0));
    check("mid_rst_sel_err", BW'(sel_err), BW'(0));

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 199) == 0);
      auto_sel = $urandom_range(0, 1);
      s        = SW'($urandom_range(0, 15));
      d        = WIDTH'($urandom);
      in_valid = ($urandom_range(0, 9) < 7);
      out_ack  = NCH'($urandom & $urandom);
      tick();
    end
    rst = 1'b0;
    in_valid = 1'b0;
    out_ack = '0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
